// File: rtl/and_or_pipe_pkg.sv
// Shared definitions for the and_or_pipe_array block: per-beat function select.
package and_or_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SEL  = 2'd0,
    MODE_AND  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_PASS = 2'd3
  } mode_t;

endpackage

// File: rtl/and_or_pipe_array_lane_func.sv
// One-bit logic cell; one instance per lane so each lane keeps its own hierarchy.
module lane_func
  import and_or_pipe_pkg::*;
(
  input  logic  in1_i,
  input  logic  in2_i,
  input  mode_t mode_i,
  output logic  res_o
);

  // Select the lane function for this beat.
  always_comb begin
    res_o = 1'b0;
    case (mode_i)
      MODE_SEL:  res_o = in1_i ? in1_i : in2_i;
      MODE_AND:  res_o = in1_i & in2_i;
      MODE_XOR:  res_o = in1_i ^ in2_i;
      MODE_PASS: res_o = in1_i;
      default:   res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/and_or_pipe_array_pipe_stage.sv
// One pipeline slot: valid bit plus result word, loaded when the slot may advance.
module pipe_stage #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Take the upstream slot on load; data only moves with a real beat so the
  // word held here stays put across bubbles.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  // Slot registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/and_or_pipe_array.sv
// Per-lane selectable logic function followed by a DEPTH-slot valid/ready pipe
// and a wrapping count of delivered beats. The output bus is ascending [0:WIDTH-1].
module and_or_pipe_array
  import and_or_pipe_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out1,
  output logic [CNT_W-1:0] xfer_count
);

  mode_t            mode_s;
  logic [WIDTH-1:0] func_res;

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_adv;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] up_data    [DEPTH];

  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
  logic             out_xfer;

  assign mode_s = mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    lane_func u_lane (
      .in1_i  (in1[i]),
      .in2_i  (in2[i]),
      .mode_i (mode_s),
      .res_o  (func_res[i])
    );
  end

  // A slot may advance when it or any slot nearer the output is empty, or the
  // head is being drained. Written as a reduction over the downstream valids
  // rather than a ripple so there is no self-referencing vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign stage_adv[k] = out_ready | ~(&stage_valid[DEPTH-1:k]);

    if (k == 0) begin : g_head_in
      assign up_valid[k] = in_valid;
      assign up_data[k]  = func_res;
    end else begin : g_chain
      assign up_valid[k] = stage_valid[k-1];
      assign up_data[k]  = stage_data[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load_i  (stage_adv[k]),
      .valid_i (up_valid[k]),
      .data_i  (up_data[k]),
      .valid_o (stage_valid[k]),
      .data_o  (stage_data[k])
    );
  end

  assign in_ready  = stage_adv[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    assign out1[i] = stage_data[DEPTH-1][i];
  end

  // Delivered-beat count, wraps naturally at 2^CNT_W.
  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_xfer) begin
      xfer_count_d = xfer_count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;

endmodule
